// File: rtl/avalon_displays7seg_pkg.sv
// Shared constants for the Avalon seven-segment display peripheral:
// register offsets, CTRL layout and the active-low hex segment table.
package avalon_displays7seg_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DIGIT_W = 8;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned HEX_W   = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RAW_BIT = 7;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLINK_BIT = 1;
    localparam int unsigned CTRL_W         = 2;

    typedef struct packed {
        logic blink_en;
        logic en;
    } ctrl_t;

    // Registers above the digit array move with the digit count.
    function automatic int unsigned ctrl_off(input int unsigned n_digits);
        return n_digits;
    endfunction

    function automatic int unsigned mask_off(input int unsigned n_digits);
        return n_digits + 1;
    endfunction

    function automatic int unsigned status_off(input int unsigned n_digits);
        return n_digits + 2;
    endfunction

    // Entry k is the active-low pattern for hex digit k (bit0=a ... bit6=g).
    localparam logic [15:0][SEG_W-1:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
module seg7_decoder
    import avalon_displays7seg_pkg::*;
(
    input  logic [HEX_W-1:0] hex,
    output logic [SEG_W-1:0] seg_c
);

    assign seg_c = SEG_LUT[hex];

endmodule

// File: rtl/avalon_displays7seg_n.sv
// Avalon-MM slave driving N_DIGITS seven-segment displays with per-digit
// hex/raw mode, global blank, per-digit blink and registered readback.
module avalon_displays7seg_n
    import avalon_displays7seg_pkg::*;
#(
    parameter int unsigned N_DIGITS  = 8,
    parameter int unsigned BLINK_DIV = 25000000,
    parameter int unsigned ADDR_W    = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         avs_address,
    input  logic                      avs_write,
    input  logic [DATA_W-1:0]         avs_writedata,
    input  logic                      avs_read,
    output logic [DATA_W-1:0]         avs_readdata,
    output logic                      avs_readdatavalid,
    output logic [SEG_W*N_DIGITS-1:0] seg_o
);

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(ctrl_off(N_DIGITS));
    localparam logic [ADDR_W-1:0] MASK_ADDR   = ADDR_W'(mask_off(N_DIGITS));
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(status_off(N_DIGITS));
    localparam logic [CNT_W-1:0]  BLINK_LAST  = CNT_W'(BLINK_DIV - 1);
    localparam logic [CTRL_W-1:0] CTRL_RESET  = CTRL_W'(1 << CTRL_EN_BIT);

    logic [DIGIT_W-1:0]        digit_q [N_DIGITS];
    ctrl_t                     ctrl_q;
    logic [N_DIGITS-1:0]       mask_q;
    logic [CNT_W-1:0]          blink_cnt_q;
    logic                      phase_q;
    logic [SEG_W-1:0]          dec_c   [N_DIGITS];
    logic [SEG_W*N_DIGITS-1:0] seg_next_c;
    logic [DATA_W-1:0]         rd_data_c;
    logic                      unused_wdata_c;

    // Only the low bits of each write are stored.
    assign unused_wdata_c = ^avs_writedata;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_dec
        seg7_decoder u_dec (
            .hex   (digit_q[g][HEX_W-1:0]),
            .seg_c (dec_c[g])
        );
    end

    // Register file writes; STATUS and unmapped offsets fall through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_DIGITS; i++) digit_q[i] <= '0;
            ctrl_q <= ctrl_t'(CTRL_RESET);
            mask_q <= '0;
        end else if (avs_write) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (avs_address == ADDR_W'(i)) digit_q[i] <= avs_writedata[DIGIT_W-1:0];
            end
            if (avs_address == CTRL_ADDR) ctrl_q <= ctrl_t'(avs_writedata[CTRL_W-1:0]);
            if (avs_address == MASK_ADDR) mask_q <= avs_writedata[N_DIGITS-1:0];
        end
    end

    // Blink prescaler; held cleared while blinking is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (!ctrl_q.blink_en) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        seg_next_c = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (ctrl_q.en && !(ctrl_q.blink_en && mask_q[i] && phase_q)) begin
                seg_next_c[SEG_W*i +: SEG_W] = digit_q[i][RAW_BIT] ? ~digit_q[i][SEG_W-1:0]
                                                                   : dec_c[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) seg_o <= '1;
        else          seg_o <= seg_next_c;
    end

    always_comb begin
        rd_data_c = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (avs_address == ADDR_W'(i)) rd_data_c = DATA_W'(digit_q[i]);
        end
        if (avs_address == CTRL_ADDR)   rd_data_c = DATA_W'(ctrl_q);
        if (avs_address == MASK_ADDR)   rd_data_c = DATA_W'(mask_q);
        if (avs_address == STATUS_ADDR) rd_data_c = DATA_W'(phase_q);
    end

    // Readback captures pre-write state, so same-cycle read+write returns old data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_data_c;
        end
    end

endmodule
